uart_wb_bridge: RTL and testbench
=================================

Name: uart_wb_bridge

Overview:
Command decoder on the system side of the UART byte interface. It turns a byte stream from a host (the testbench UART partner, or a PC in hardware) into 32-bit Wishbone master cycles and returns the results over UART. It sits between the system's uart instance (rx_data/rx_avail/rx_ack, tx_data/tx_wr/tx_busy) and a spare Wishbone master port of the bus arbiter. It is used for memory load and peek/poke debugging alongside the LM32.

Parameters:
rx_timeout_cycles, 1000000, idle clocks allowed between bytes of one command before the partial command is dropped
wb_timeout_cycles, 255, clocks allowed for wb_ack_i before the bus cycle is aborted

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte from uart
rx_avail  in  1  byte valid; held until acknowledged
rx_ack  out  1  one-cycle pulse: byte consumed
tx_data  out  8  byte to transmit
tx_wr  out  1  one-cycle transmit strobe
tx_busy  in  1  uart transmitter busy
wb_adr_o  out  32  Wishbone address
wb_dat_o  out  32  Wishbone write data
wb_dat_i  in  32  Wishbone read data
wb_sel_o  out  4  byte select; always 4'b1111
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_ack_i  in  1  acknowledge

Behaviour:
- Reset values: rx_ack=0, tx_wr=0, tx_data=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=4'b1111, state IDLE, all counters 0. A reset asserted mid-operation aborts immediately. cyc/stb drop in the cycle after the reset edge. No response byte is sent.
- Protocol. All multi-byte fields are sent MSB first.
  - 0x57 'W', then adr[4], then dat[4]: Wishbone write; respond with 0x06.
  - 0x52 'R', then adr[4]: Wishbone read; respond with the 4 data bytes, MSB first.
  - Any other byte in IDLE is consumed (rx_ack pulsed) and discarded. No response.
- RX handshake: when rx_avail=1 and no rx_ack was issued in the previous cycle, latch rx_data and pulse rx_ack for 1 cycle. rx_avail is ignored in the cycle right after an rx_ack, so a byte is never consumed twice.
- States: IDLE -> ADDR -> (DATA if write) -> BUS -> RESP -> IDLE.
  - ADDR and DATA each use a 2-bit byte counter. Each byte shifts in: reg <= {reg[23:0], byte}. Leave the state when the counter wraps from 3 to 0.
- Inter-byte timeout: in ADDR or DATA, a counter is cleared on every consumed byte. When it reaches rx_timeout_cycles, go to IDLE with no response. The next byte is then decoded as a command.
- BUS:
  - Assert cyc=stb=1, we per command, adr/dat from the shift registers, in the cycle after entry.
  - On the first cycle with wb_ack_i=1: drop cyc/stb on the next edge. For a read, latch wb_dat_i on that same ack edge. Then go to RESP.
  - wb_ack_i outside BUS is ignored.
  - Latency from the last command byte's rx_ack to cyc rising is at most 2 cycles.
- Bus timeout: if no ack after wb_timeout_cycles clocks with cyc high, drop cyc/stb and respond with the single byte 0x15 (NAK) for both R and W.
- RESP / TX handshake:
  - Issue tx_wr for 1 cycle with tx_data valid only when tx_busy=0.
  - After each tx_wr, wait 1 cycle before sampling tx_busy again, because busy rises the cycle after the strobe.
  - Read responses send 4 bytes; W and NAK responses send 1.
  - Return to IDLE one cycle after the last tx_wr.
- Bytes arriving during BUS or RESP are not consumed (rx_ack stays 0). They stay pending in the uart and are decoded after the return to IDLE.
- Only one bus cycle is outstanding at a time. There is no pipelining and no bursts.

Test Plan:
- Write: send 57 00 00 10 00 DE AD BE EF with a slave acking after 3 cycles -> one cycle with adr=0x00001000, dat=0xDEADBEEF, we=1, sel=F; UART then returns 06.
- Read: send 52 00 00 10 00 with the slave returning 0x12345678 -> we=0, adr=0x00001000; UART returns 12 34 56 78 in order, each tx_wr only while tx_busy=0.
- Bus timeout: send 52 00 00 00 04 with no slave ack -> cyc high for exactly wb_timeout_cycles, then drops; UART returns 15; a following valid W command completes normally.
- Garbage and partial command: send AA, then 57 00 00 then silence for more than rx_timeout_cycles, then 52 00 00 00 08 -> AA and the partial command are consumed with no response; the read at 0x00000008 executes.
- Back-to-back: two R commands sent without gaps, the second arriving during the first's RESP -> two bus cycles and 8 response bytes in order; no rx_ack while in BUS/RESP; no byte is dropped or duplicated.
- Reset while cyc=1 in BUS -> cyc/stb/tx_wr are 0 the next cycle; no response byte is sent; a subsequent W command works.

Source files
------------

// File: rtl/uart_wb_bridge.sv
// UART command decoder driving a single 32-bit Wishbone master port.
// Commands: 'W' adr[4] dat[4] -> 0x06, 'R' adr[4] -> dat[4]; bus timeout -> 0x15.
module uart_wb_bridge #(
    parameter int unsigned rx_timeout_cycles = 1000000,
    parameter int unsigned wb_timeout_cycles = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    // Handshakes: a byte is taken when rx_avail=1 and rx_ack was low last cycle;
    // tx_wr is issued only when tx_busy=0 and never in two consecutive cycles.
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    localparam int RXT_W = $clog2(rx_timeout_cycles + 1);
    localparam int WBT_W = $clog2(wb_timeout_cycles + 1);

    state_t             state, state_next;
    logic [RXT_W-1:0]   rx_timer;
    logic [WBT_W-1:0]   wb_timer;
    logic [1:0]         byte_cnt;
    logic               is_write;
    logic [31:0]        tx_shift;
    logic [1:0]         tx_left;
    logic               tx_last;
    logic               rx_take;
    logic               rx_expired;
    logic               wb_expired;
    logic               tx_go;

    assign wb_sel_o   = 4'b1111;
    assign rx_take    = rx_avail && !rx_ack && (state == IDLE || state == ADDR || state == DATA);
    assign rx_expired = (rx_timer == RXT_W'(rx_timeout_cycles));
    assign wb_expired = (wb_timer == WBT_W'(wb_timeout_cycles - 1));
    assign tx_go      = (state == RESP) && !tx_busy && !tx_wr && !tx_last;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (rx_take && (rx_data == 8'h57 || rx_data == 8'h52)) state_next = ADDR;
            ADDR: begin
                if (rx_take) begin
                    if (byte_cnt == 2'd3) state_next = is_write ? DATA : BUS;
                end else if (rx_expired) begin
                    state_next = IDLE;
                end
            end
            DATA: begin
                if (rx_take) begin
                    if (byte_cnt == 2'd3) state_next = BUS;
                end else if (rx_expired) begin
                    state_next = IDLE;
                end
            end
            BUS:  if (wb_cyc_o && (wb_ack_i || wb_expired)) state_next = RESP;
            RESP: if (tx_wr && tx_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ack   <= 1'b0;
            tx_wr    <= 1'b0;
            tx_data  <= 8'h00;
            wb_adr_o <= 32'h0;
            wb_dat_o <= 32'h0;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            rx_timer <= '0;
            wb_timer <= '0;
            byte_cnt <= 2'd0;
            is_write <= 1'b0;
            tx_shift <= 32'h0;
            tx_left  <= 2'd0;
            tx_last  <= 1'b0;
        end else begin
            rx_ack <= rx_take;
            tx_wr  <= tx_go;
            case (state)
                IDLE: begin
                    byte_cnt <= 2'd0;
                    rx_timer <= '0;
                    if (rx_take) is_write <= (rx_data == 8'h57);
                end
                ADDR, DATA: begin
                    if (rx_take) begin
                        rx_timer <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (state == ADDR) wb_adr_o <= {wb_adr_o[23:0], rx_data};
                        else               wb_dat_o <= {wb_dat_o[23:0], rx_data};
                    end else begin
                        rx_timer <= rx_timer + RXT_W'(1);
                    end
                end
                BUS: begin
                    if (!wb_cyc_o) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= is_write;
                        wb_timer <= '0;
                    end else if (wb_ack_i || wb_expired) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        tx_last  <= 1'b0;
                        // Ack takes priority over a timeout landing on the same edge.
                        if (wb_ack_i) begin
                            tx_shift <= is_write ? {8'h06, 24'h0} : wb_dat_i;
                            tx_left  <= is_write ? 2'd0 : 2'd3;
                        end else begin
                            tx_shift <= {8'h15, 24'h0};
                            tx_left  <= 2'd0;
                        end
                    end else begin
                        wb_timer <= wb_timer + WBT_W'(1);
                    end
                end
                RESP: begin
                    if (tx_go) begin
                        tx_data  <= tx_shift[31:24];
                        tx_shift <= {tx_shift[23:0], 8'h00};
                        tx_left  <= tx_left - 2'd1;
                        if (tx_left == 2'd0) tx_last <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge: UART host driver, Wishbone slave model,
// UART transmitter model with busy behaviour, and per-scenario checks.
module tb_uart_wb_bridge;

    localparam int RXT = 100;
    localparam int WBT = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_avail;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;

    uart_wb_bridge #(.rx_timeout_cycles(RXT), .wb_timeout_cycles(WBT)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // slave model and monitors state
    bit          slave_en = 1'b1;
    bit          slave_inv = 1'b0;
    int          slave_delay = 3;
    logic [31:0] slave_data = 32'h0;
    logic [31:0] adr_q[$];
    logic [31:0] dat_q[$];
    logic        we_q[$];
    logic [3:0]  sel_q[$];
    int          cyc_run = 0;
    int          last_cyc_len = 0;
    int          ack_during_cyc = 0;
    int          rx_ack_total = 0;
    int          busy_viol = 0;
    int          busy_len = 4;
    logic [7:0]  tx_q[$];
    logic [7:0]  exp_q[$];

    // Wishbone slave: acks after slave_delay cycles of cyc&stb, logs each acked cycle
    initial begin
        int cnt;
        cnt = 0;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (wb_ack_i) begin
                wb_ack_i = 1'b0;
                cnt = 0;
            end else if (wb_cyc_o && wb_stb_o) begin
                cnt++;
                if (slave_en && cnt >= slave_delay) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = slave_inv ? ~wb_adr_o : slave_data;
                    adr_q.push_back(wb_adr_o);
                    dat_q.push_back(wb_dat_o);
                    we_q.push_back(wb_we_o);
                    sel_q.push_back(wb_sel_o);
                end
            end else begin
                cnt = 0;
            end
            if (wb_cyc_o) cyc_run++;
            else if (cyc_run != 0) begin
                last_cyc_len = cyc_run;
                cyc_run = 0;
            end
            if (wb_cyc_o && rx_ack) ack_during_cyc++;
            if (rx_ack) rx_ack_total++;
        end
    end

    // UART transmitter: busy rises the cycle after a strobe, lasts busy_len cycles
    initial begin
        bit pend;
        bit new_pend;
        int bcnt;
        pend = 1'b0;
        bcnt = 0;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            new_pend = 1'b0;
            if (tx_wr) begin
                if (tx_busy) busy_viol++;
                tx_q.push_back(tx_data);
                new_pend = 1'b1;
            end
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) tx_busy = 1'b0;
            end
            if (pend) begin
                tx_busy = 1'b1;
                bcnt = busy_len;
            end
            pend = new_pend;
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, output bit ok);
        rx_data = b;
        rx_avail = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (rx_ack) begin
                ok = 1'b1;
                break;
            end
        end
        rx_avail = 1'b0;
    endtask

    task automatic send_cmd(input logic [71:0] v, input int n, output bit ok);
        bit b_ok;
        ok = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            send_byte(v[8*i +: 8], b_ok);
            if (!b_ok) ok = 1'b0;
        end
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        adr_q.delete(); dat_q.delete(); we_q.delete(); sel_q.delete();
        tx_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_avail = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_ack !== 1'b0) begin errors++; $display("FAIL reset_rx_ack got %b exp 0", rx_ack); end
        checks++; if (tx_wr !== 1'b0) begin errors++; $display("FAIL reset_tx_wr got %b exp 0", tx_wr); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
        checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin
            errors++; $display("FAIL reset_cyc_stb_we got %b%b%b exp 000", wb_cyc_o, wb_stb_o, wb_we_o); end
        checks++; if (wb_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr got %h exp 0", wb_adr_o); end
        checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h exp 0", wb_dat_o); end
        checks++; if (wb_sel_o !== 4'hF) begin errors++; $display("FAIL reset_sel got %h exp F", wb_sel_o); end
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        bit ok;
        clear_logs();
        slave_en = 1'b1; slave_inv = 1'b0; slave_delay = 3;
        send_cmd(72'h57_00001000_DEADBEEF, 9, ok);
        checks++; if (!ok) begin errors++; $display("FAIL write_rx_accept got stall exp all bytes acked"); end
        wait_tx(1, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL write_resp_timeout got %0d bytes exp 1", tx_q.size()); end
        checks++; if (adr_q.size() != 1) begin errors++; $display("FAIL write_bus_count got %0d exp 1", adr_q.size()); end
        checks++; if (adr_q[0] !== 32'h00001000) begin errors++; $display("FAIL write_adr got %h exp 00001000", adr_q[0]); end
        checks++; if (dat_q[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_dat got %h exp deadbeef", dat_q[0]); end
        checks++; if (we_q[0] !== 1'b1) begin errors++; $display("FAIL write_we got %b exp 1", we_q[0]); end
        checks++; if (sel_q[0] !== 4'hF) begin errors++; $display("FAIL write_sel got %h exp F", sel_q[0]); end
        exp_q.push_back(8'h06);
        checks++; if (tx_q.size() != exp_q.size()) begin errors++; $display("FAIL write_tx_count got %0d exp %0d", tx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL write_tx_byte%0d got %h exp %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]); end
        end
        checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL write_cyc_idle got %b exp 0", wb_cyc_o); end
    endtask

    task automatic test_read();
        bit ok;
        clear_logs();
        slave_en = 1'b1; slave_inv = 1'b0; slave_delay = 2; slave_data = 32'h12345678;
        send_cmd(72'h52_00001000, 5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL read_rx_accept got stall exp all bytes acked"); end
        wait_tx(4, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL read_resp_timeout got %0d bytes exp 4", tx_q.size()); end
        checks++; if (adr_q.size() != 1) begin errors++; $display("FAIL read_bus_count got %0d exp 1", adr_q.size()); end
        checks++; if (adr_q[0] !== 32'h00001000) begin errors++; $display("FAIL read_adr got %h exp 00001000", adr_q[0]); end
        checks++; if (we_q[0] !== 1'b0) begin errors++; $display("FAIL read_we got %b exp 0", we_q[0]); end
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        checks++; if (tx_q.size() != exp_q.size()) begin errors++; $display("FAIL read_tx_count got %0d exp %0d", tx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL read_tx_byte%0d got %h exp %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]); end
        end
        checks++; if (busy_viol != 0) begin errors++; $display("FAIL read_tx_while_busy got %0d exp 0", busy_viol); end
    endtask

    task automatic test_bus_timeout();
        bit ok;
        clear_logs();
        slave_en = 1'b0;
        send_cmd(72'h52_00000004, 5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bto_rx_accept got stall exp all bytes acked"); end
        wait_tx(1, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bto_resp_timeout got %0d bytes exp 1", tx_q.size()); end
        checks++; if (last_cyc_len != WBT) begin errors++; $display("FAIL bto_cyc_len got %0d exp %0d", last_cyc_len, WBT); end
        checks++; if (adr_q.size() != 0) begin errors++; $display("FAIL bto_acked_cycles got %0d exp 0", adr_q.size()); end
        checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h15) begin
            errors++; $display("FAIL bto_nak got %0d bytes first %h exp 1 byte 15", tx_q.size(), tx_q[0]); end
        clear_logs();
        slave_en = 1'b1; slave_delay = 1;
        send_cmd(72'h57_00000020_11223344, 9, ok);
        wait_tx(1, 300, ok);
        checks++; if (adr_q.size() != 1 || adr_q[0] !== 32'h00000020 || dat_q[0] !== 32'h11223344 || we_q[0] !== 1'b1) begin
            errors++; $display("FAIL bto_followup_write got n=%0d adr %h dat %h exp 1 00000020 11223344", adr_q.size(), adr_q[0], dat_q[0]); end
        checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
            errors++; $display("FAIL bto_followup_ack got %0d bytes first %h exp 1 byte 06", tx_q.size(), tx_q[0]); end
    endtask

    task automatic test_garbage_partial();
        bit ok;
        bit ok2;
        int acks0;
        clear_logs();
        slave_en = 1'b1; slave_delay = 2; slave_data = 32'hA5A55A5A;
        acks0 = rx_ack_total;
        send_byte(8'hAA, ok);
        send_cmd(72'h570000, 3, ok2);
        checks++; if (!ok || !ok2) begin errors++; $display("FAIL garb_rx_accept got stall exp 4 bytes acked"); end
        repeat (RXT + 50) @(posedge clk);
        #1;
        checks++; if (rx_ack_total - acks0 != 4) begin errors++; $display("FAIL garb_ack_count got %0d exp 4", rx_ack_total - acks0); end
        checks++; if (tx_q.size() != 0 || adr_q.size() != 0) begin
            errors++; $display("FAIL garb_no_activity got tx %0d bus %0d exp 0 0", tx_q.size(), adr_q.size()); end
        send_cmd(72'h52_00000008, 5, ok);
        wait_tx(4, 500, ok);
        checks++; if (adr_q.size() != 1 || adr_q[0] !== 32'h00000008 || we_q[0] !== 1'b0) begin
            errors++; $display("FAIL garb_read_cycle got n=%0d adr %h we %b exp 1 00000008 0", adr_q.size(), adr_q[0], we_q[0]); end
        exp_q = '{8'hA5, 8'hA5, 8'h5A, 8'h5A};
        checks++; if (tx_q.size() != exp_q.size()) begin errors++; $display("FAIL garb_tx_count got %0d exp %0d", tx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL garb_tx_byte%0d got %h exp %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit ok2;
        int acks0;
        clear_logs();
        slave_en = 1'b1; slave_inv = 1'b1; slave_delay = 3;
        acks0 = rx_ack_total;
        ack_during_cyc = 0;
        send_cmd(72'h52_00000100, 5, ok);
        send_cmd(72'h52_00000204, 5, ok2);
        checks++; if (!ok || !ok2) begin errors++; $display("FAIL b2b_rx_accept got stall exp 10 bytes acked"); end
        wait_tx(8, 800, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_resp_timeout got %0d bytes exp 8", tx_q.size()); end
        checks++; if (adr_q.size() != 2 || adr_q[0] !== 32'h00000100 || adr_q[1] !== 32'h00000204) begin
            errors++; $display("FAIL b2b_bus_cycles got n=%0d adr0 %h adr1 %h exp 2 00000100 00000204", adr_q.size(), adr_q[0], adr_q[1]); end
        checks++; if (rx_ack_total - acks0 != 10) begin errors++; $display("FAIL b2b_ack_count got %0d exp 10", rx_ack_total - acks0); end
        checks++; if (ack_during_cyc != 0) begin errors++; $display("FAIL b2b_ack_in_bus got %0d exp 0", ack_during_cyc); end
        exp_q = '{8'hFF, 8'hFF, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'hFB};
        checks++; if (tx_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_tx_count got %0d exp %0d", tx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL b2b_tx_byte%0d got %h exp %h", i, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_q[i]); end
        end
        checks++; if (busy_viol != 0) begin errors++; $display("FAIL b2b_tx_while_busy got %0d exp 0", busy_viol); end
        slave_inv = 1'b0;
    endtask

    task automatic test_reset_mid_bus();
        bit ok;
        bit seen;
        clear_logs();
        slave_en = 1'b0;
        send_cmd(72'h52_00000040, 5, ok);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (wb_cyc_o) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_bus_cyc_start got 0 exp cyc=1 within 20 cycles"); end
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || tx_wr !== 1'b0) begin
            errors++; $display("FAIL rst_bus_abort got cyc %b stb %b tx_wr %b exp 000", wb_cyc_o, wb_stb_o, tx_wr); end
        reset = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        checks++; if (tx_q.size() != 0) begin errors++; $display("FAIL rst_no_resp got %0d bytes exp 0", tx_q.size()); end
        slave_en = 1'b1; slave_delay = 2;
        send_cmd(72'h57_00000044_CAFEF00D, 9, ok);
        wait_tx(1, 300, ok);
        checks++; if (adr_q.size() != 1 || adr_q[0] !== 32'h00000044 || dat_q[0] !== 32'hCAFEF00D || we_q[0] !== 1'b1) begin
            errors++; $display("FAIL rst_followup_write got n=%0d adr %h dat %h exp 1 00000044 cafef00d", adr_q.size(), adr_q[0], dat_q[0]); end
        checks++; if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
            errors++; $display("FAIL rst_followup_ack got %0d bytes first %h exp 1 byte 06", tx_q.size(), tx_q[0]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bus_timeout();
        test_garbage_partial();
        test_back_to_back();
        test_reset_mid_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
